// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and state encoding for the IF-stage program counter.
package pc_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int unsigned PC_INC       = 4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: hazard/imem/redirect inputs and the fetch PC outputs.
interface pc_fetch_unit_if #(parameter int PC_W = 32);
  logic            stall;
  logic            im_ready;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic [PC_W-1:0] pc;
  logic            fetch_valid;
  logic            redirect_pend;
  logic            align_err;

  modport master (
    output stall, im_ready, redirect_valid, redirect_pc,
    input  pc, fetch_valid, redirect_pend, align_err
  );

  modport slave (
    input  stall, im_ready, redirect_valid, redirect_pc,
    output pc, fetch_valid, redirect_pend, align_err
  );
endinterface

// File: rtl/pc_fetch_unit_buf.sv
// Single-entry redirect buffer; a new load overwrites an older target.
module pc_fetch_unit_buf #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic [PC_W-1:0] load_pc,
  output logic [PC_W-1:0] pend_pc,
  output logic            pend
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_pc <= '0;
      pend    <= 1'b0;
    end else if (load) begin
      pend_pc <= load_pc;
      pend    <= 1'b1;
    end else if (clear) begin
      pend    <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register and next-PC sequencer with stall/imem gating and redirect buffering.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic           clk,
  input  logic           reset,
  pc_fetch_unit_if.slave bus
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc4, pend_pc;
  logic            pend, buf_load, buf_clr;
  logic            adv, good, bad, err_q;

  // Misaligned redirects are dropped entirely; they only raise the sticky flag.
  assign good = bus.redirect_valid & (bus.redirect_pc[1:0] == 2'b00);
  assign bad  = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
  assign adv  = (state_q != ST_BOOT) & ~bus.stall & bus.im_ready;
  assign pc4  = pc_q + PC_W'(PC_INC);

  pc_fetch_unit_buf #(.PC_W(PC_W)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .load    (buf_load),
    .clear   (buf_clr),
    .load_pc (bus.redirect_pc),
    .pend_pc (pend_pc),
    .pend    (pend)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_load = 1'b0;
    buf_clr  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (good) begin
          buf_load = 1'b1;
          state_d  = ST_HOLD;
        end else begin
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (adv) begin
          pc_d = good ? bus.redirect_pc : pc4;
        end else if (good) begin
          buf_load = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // A live redirect on the releasing cycle beats the buffered one.
        if (adv) begin
          pc_d    = good ? bus.redirect_pc : pend_pc;
          buf_clr = 1'b1;
          state_d = ST_RUN;
        end else if (good) begin
          buf_load = 1'b1;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (bad) err_q <= 1'b1;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.fetch_valid   = (state_q != ST_BOOT);
  assign bus.redirect_pend = pend;
  assign bus.align_err     = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scenarios plus random traffic against a behavioural fetch-PC model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  // model state
  logic [31:0] m_pc, m_ppc;
  bit          m_fv, m_pend, m_err;

  pc_fetch_unit_if #(.PC_W(32)) fif ();

  pc_fetch_unit #(.PC_W(32), .RESET_PC(RPC)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (fif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},   fif.pc,                   m_pc);
    chk({tag, ".fv"},   {31'd0, fif.fetch_valid},   {31'd0, m_fv});
    chk({tag, ".pend"}, {31'd0, fif.redirect_pend}, {31'd0, m_pend});
    chk({tag, ".err"},  {31'd0, fif.align_err},     {31'd0, m_err});
  endtask

  task automatic mdl_reset();
    m_pc = RPC; m_ppc = '0; m_fv = 0; m_pend = 0; m_err = 0;
  endtask

  // One clock edge in terms of the rules: what gets fetched next, what is remembered.
  task automatic mdl_step(input bit s, input bit r, input bit rv, input logic [31:0] rpc);
    bit ok, adv;
    ok  = rv && (rpc % 4 == 0);
    adv = m_fv && !s && r;
    if (rv && !ok) m_err = 1;
    if (!m_fv) begin
      m_fv = 1;
      if (ok) begin m_pend = 1; m_ppc = rpc; end
    end else if (adv) begin
      if (ok)          m_pc = rpc;
      else if (m_pend) m_pc = m_ppc;
      else             m_pc = m_pc + 32'd4;
      m_pend = 0;
    end else if (ok) begin
      m_pend = 1; m_ppc = rpc;
    end
  endtask

  // Called just after a falling edge: drive, clock, then check on the next falling edge.
  task automatic cyc(input bit s, input bit r, input bit rv, input logic [31:0] rpc,
                     input string tag);
    fif.stall = s; fif.im_ready = r; fif.redirect_valid = rv; fif.redirect_pc = rpc;
    @(posedge clk);
    mdl_step(s, r, rv, rpc);
    @(negedge clk);
    chk_model(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    mdl_reset();
    #1;
    chk({tag, ".rst_pc"},   fif.pc, RPC);
    chk({tag, ".rst_pend"}, {31'd0, fif.redirect_pend}, 32'd0);
    chk_model({tag, ".rst"});
    fif.stall = 0; fif.im_ready = 1; fif.redirect_valid = 0; fif.redirect_pc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_model({tag, ".boot"});
  endtask

  initial begin
    rst_n = 1'b0;
    fif.stall = 0; fif.im_ready = 1; fif.redirect_valid = 0; fif.redirect_pc = '0;
    repeat (2) @(negedge clk);
    do_reset("init");
    chk("boot_fv", {31'd0, fif.fetch_valid}, 32'd0);

    // sequential fetch
    cyc(0, 1, 0, 0, "seq0"); chk("seq0_pc", fif.pc, 32'h3000);
    cyc(0, 1, 0, 0, "seq1"); chk("seq1_pc", fif.pc, 32'h3004);
    cyc(0, 1, 0, 0, "seq2"); chk("seq2_pc", fif.pc, 32'h3008);
    cyc(0, 1, 0, 0, "seq3");
    cyc(0, 1, 0, 0, "seq4"); chk("seq4_pc", fif.pc, 32'h3010);

    // stall holds
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, "stall");
    chk("stall_pc", fif.pc, 32'h3010);
    cyc(0, 1, 0, 0, "unstall"); chk("unstall_pc", fif.pc, 32'h3014);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, "to3020");
    chk("at3020", fif.pc, 32'h3020);

    // redirect on advance
    cyc(0, 1, 1, 32'h3400, "rd_adv");
    chk("rd_adv_pc", fif.pc, 32'h3400);
    chk("rd_adv_pend", {31'd0, fif.redirect_pend}, 32'd0);

    // buffered redirects, latest wins
    cyc(0, 1, 1, 32'h3020, "back3020");
    cyc(0, 0, 1, 32'h3100, "buf1");
    cyc(0, 0, 1, 32'h3200, "buf2");
    chk("buf_pend", {31'd0, fif.redirect_pend}, 32'd1);
    chk("buf_pc", fif.pc, 32'h3020);
    cyc(0, 1, 0, 0, "buf_rel");
    chk("buf_rel_pc", fif.pc, 32'h3200);
    chk("buf_rel_pend", {31'd0, fif.redirect_pend}, 32'd0);

    // misaligned redirect ignored
    cyc(0, 1, 1, 32'h3030, "to3030");
    cyc(0, 1, 1, 32'h3002, "misal");
    chk("misal_pc", fif.pc, 32'h3034);
    chk("misal_err", {31'd0, fif.align_err}, 32'd1);
    cyc(0, 1, 0, 0, "err_sticky");
    chk("err_sticky", {31'd0, fif.align_err}, 32'd1);

    // wrap, then reset in HOLD
    cyc(0, 1, 1, 32'hFFFF_FFFC, "to_top");
    cyc(0, 1, 0, 0, "wrap");
    chk("wrap_pc", fif.pc, 32'h0000_0000);
    cyc(1, 1, 1, 32'h0000_5000, "hold");
    chk("hold_pend", {31'd0, fif.redirect_pend}, 32'd1);
    do_reset("mid_hold");
    chk("mid_hold_err", {31'd0, fif.align_err}, 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      if ($urandom_range(0, 249) == 0) begin
        do_reset("rnd_rst");
      end else begin
        t = $urandom;
        if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) < 3, t, "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
